// File: rtl/alu_issue_seq.sv
// Byte-stream instruction assembler and issue sequencer for the 16-bit ALU.
// Optional: ALU_ISSUE_SHAMT_CLAMP_EN clamps shl/shr amounts above 16 to 16.
module alu_issue_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic             inst_add,
  output logic             inst_sub,
  output logic             inst_test,
  output logic             inst_and,
  output logic             inst_or,
  output logic             inst_xor,
  output logic             inst_not,
  output logic             inst_shl,
  output logic             inst_shr,
  output logic [15:0]      rhs,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_OPCODE,
    S_IMM_LO,
    S_IMM_HI,
    S_ISSUE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [8:0]       r_strb;
  logic [15:0]      r_rhs;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  logic       w_acc;
  logic       w_hs;
  logic [3:0] w_op;
  logic       w_long;
  logic       w_legal;
  logic       w_noopd;
  logic [8:0] w_dec;
  logic [8:0] w_strb;

  assign w_op    = in_data[7:4];
  assign w_long  = in_data[3];
  assign w_legal = (w_op <= 4'd8);
  assign w_noopd = (w_op == 4'd2) || (w_op == 4'd6);
  assign w_dec   = w_legal ? (9'd1 << w_op) : 9'd0;
  assign w_acc   = in_valid & in_ready;
  assign w_hs    = (r_state == S_ISSUE) & issue_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_OPCODE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_OPCODE: begin
        if (w_acc && w_legal) begin
          if (w_noopd || !w_long) w_next = S_ISSUE;
          else                    w_next = S_IMM_LO;
        end
      end
      S_IMM_LO: if (w_acc) w_next = S_IMM_HI;
      S_IMM_HI: if (w_acc) w_next = S_ISSUE;
      S_ISSUE:  if (w_hs)  w_next = S_OPCODE;
      default:  w_next = S_OPCODE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strb    <= '0;
      r_rhs     <= '0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_illegal <= 1'b0;
      if (w_acc && r_state == S_OPCODE) begin
        r_illegal <= ~w_legal;
        if (w_legal) begin
          r_strb <= w_dec;
          if (w_noopd)      r_rhs <= '0;
          else if (!w_long) r_rhs <= {13'd0, in_data[2:0]};
        end
      end
      if (w_acc && r_state == S_IMM_LO) r_rhs[7:0]  <= in_data;
      if (w_acc && r_state == S_IMM_HI) r_rhs[15:8] <= in_data;
      if (w_hs) begin
        r_strb    <= '0;
        r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign in_ready    = (r_state != S_ISSUE);
  assign issue_valid = (r_state == S_ISSUE);
  assign busy        = (r_state != S_OPCODE);
  assign illegal     = r_illegal;
  assign retired     = r_retired;
  // Op is latched at opcode time; strobes only show once the issue is live.
  assign w_strb      = r_strb & {9{issue_valid}};

  assign inst_add  = w_strb[0];
  assign inst_sub  = w_strb[1];
  assign inst_test = w_strb[2];
  assign inst_and  = w_strb[3];
  assign inst_or   = w_strb[4];
  assign inst_xor  = w_strb[5];
  assign inst_not  = w_strb[6];
  assign inst_shl  = w_strb[7];
  assign inst_shr  = w_strb[8];

`ifdef ALU_ISSUE_SHAMT_CLAMP_EN
  logic w_shift;
  assign w_shift = r_strb[7] | r_strb[8];
  assign rhs = (w_shift && r_rhs > 16'd16) ? 16'd16 : r_rhs;
`else
  assign rhs = r_rhs;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed self-checking bench for alu_issue_seq (CNT_W=4 instance).
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic        inst_add, inst_sub, inst_test, inst_and, inst_or;
  logic        inst_xor, inst_not, inst_shl, inst_shr;
  logic [15:0] rhs;
  logic        illegal;
  logic [3:0]  retired;
  logic        busy;
  logic [8:0]  strb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign strb = {inst_shr, inst_shl, inst_not, inst_xor, inst_or,
                 inst_and, inst_test, inst_sub, inst_add};

  alu_issue_seq #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .inst_add(inst_add), .inst_sub(inst_sub), .inst_test(inst_test),
    .inst_and(inst_and), .inst_or(inst_or), .inst_xor(inst_xor),
    .inst_not(inst_not), .inst_shl(inst_shl), .inst_shr(inst_shr),
    .rhs(rhs), .illegal(illegal), .retired(retired), .busy(busy)
  );

  task automatic do_reset();
    in_valid = 1'b0;
    issue_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (!in_ready) begin
      n_bad++;
      $display("FAIL send_timeout byte=%h in_ready=%b want 1", b, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    issue_ready = 1'b1;
    @(posedge clk); #1;
    issue_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({in_ready, issue_valid, strb, rhs, illegal, retired, busy} !==
        {1'b1, 1'b0, 9'd0, 16'd0, 1'b0, 4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset rdy=%b iv=%b strb=%h rhs=%h ill=%b ret=%h busy=%b",
               in_ready, issue_valid, strb, rhs, illegal, retired, busy);
    end
  endtask

  task automatic test_short();
    send(8'h05);
    n_cmp++;
    if ({issue_valid, in_ready, busy, strb, rhs} !==
        {1'b1, 1'b0, 1'b1, 9'h001, 16'h0005}) begin
      n_bad++;
      $display("FAIL short_issue iv=%b rdy=%b busy=%b strb=%h rhs=%h want 1 0 1 001 0005",
               issue_valid, in_ready, busy, strb, rhs);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({issue_valid, in_ready, strb, rhs, retired} !==
          {1'b1, 1'b0, 9'h001, 16'h0005, 4'd0}) begin
        n_bad++;
        $display("FAIL short_hold%0d iv=%b rdy=%b strb=%h rhs=%h ret=%h",
                 i, issue_valid, in_ready, strb, rhs, retired);
      end
    end
    handshake();
    n_cmp++;
    if ({retired, issue_valid, strb, busy, in_ready} !==
        {4'd1, 1'b0, 9'd0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL short_done ret=%h iv=%b strb=%h busy=%b rdy=%b want 1 0 000 0 1",
               retired, issue_valid, strb, busy, in_ready);
    end
  endtask

  task automatic test_long();
    send(8'h18);
    send(8'h34);
    send(8'h12);
    n_cmp++;
    if ({issue_valid, strb, rhs} !== {1'b1, 9'h002, 16'h1234}) begin
      n_bad++;
      $display("FAIL long_b2b iv=%b strb=%h rhs=%h want 1 002 1234",
               issue_valid, strb, rhs);
    end
    handshake();
    send(8'h18);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, in_ready, issue_valid, strb} !== {1'b1, 1'b1, 1'b0, 9'd0}) begin
      n_bad++;
      $display("FAIL long_gap_lo busy=%b rdy=%b iv=%b strb=%h want 1 1 0 000",
               busy, in_ready, issue_valid, strb);
    end
    send(8'h34);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, issue_valid} !== {1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL long_gap_hi busy=%b iv=%b want 1 0", busy, issue_valid);
    end
    send(8'h12);
    n_cmp++;
    if ({issue_valid, strb, rhs, retired} !== {1'b1, 9'h002, 16'h1234, 4'd2}) begin
      n_bad++;
      $display("FAIL long_gap iv=%b strb=%h rhs=%h ret=%h want 1 002 1234 2",
               issue_valid, strb, rhs, retired);
    end
    handshake();
    n_cmp++;
    if (retired !== 4'd3) begin
      n_bad++;
      $display("FAIL long_retired got %h want 3", retired);
    end
  endtask

  task automatic test_illegal();
    send(8'h9F);
    n_cmp++;
    if ({illegal, issue_valid, strb, in_ready, busy} !==
        {1'b1, 1'b0, 9'd0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL illegal_pulse ill=%b iv=%b strb=%h rdy=%b busy=%b want 1 0 000 1 0",
               illegal, issue_valid, strb, in_ready, busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({illegal, issue_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL illegal_clear ill=%b iv=%b want 0 0", illegal, issue_valid);
    end
    send(8'h60);
    n_cmp++;
    if ({issue_valid, strb, rhs, illegal} !== {1'b1, 9'h040, 16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL not_issue iv=%b strb=%h rhs=%h ill=%b want 1 040 0000 0",
               issue_valid, strb, rhs, illegal);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    send(8'h78);
    send(8'hFF);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, issue_valid, strb, rhs, illegal, retired, busy} !==
        {1'b1, 1'b0, 9'd0, 16'd0, 1'b0, 4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid rdy=%b iv=%b strb=%h rhs=%h ill=%b ret=%h busy=%b",
               in_ready, issue_valid, strb, rhs, illegal, retired, busy);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    send(8'h31);
    n_cmp++;
    if ({issue_valid, strb, rhs} !== {1'b1, 9'h008, 16'h0001}) begin
      n_bad++;
      $display("FAIL and_after_rst iv=%b strb=%h rhs=%h want 1 008 0001",
               issue_valid, strb, rhs);
    end
    handshake();
  endtask

  task automatic test_clamp();
    logic [15:0] exp_sh;
`ifdef ALU_ISSUE_SHAMT_CLAMP_EN
    exp_sh = 16'd16;
`else
    exp_sh = 16'd32;
`endif
    send(8'h88);
    send(8'h20);
    send(8'h00);
    n_cmp++;
    if ({issue_valid, strb, rhs} !== {1'b1, 9'h100, exp_sh}) begin
      n_bad++;
      $display("FAIL shr_clamp iv=%b strb=%h rhs=%h want 1 100 %h",
               issue_valid, strb, rhs, exp_sh);
    end
    handshake();
    send(8'h08);
    send(8'h20);
    send(8'h00);
    n_cmp++;
    if ({strb, rhs} !== {9'h001, 16'd32}) begin
      n_bad++;
      $display("FAIL add_noclamp strb=%h rhs=%h want 001 0020", strb, rhs);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_data = 8'h01;
    in_valid = 1'b1;
    issue_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      if (i == 31) in_valid = 1'b0;
      n_cmp++;
      if (issue_valid !== (i % 2 == 0)) begin
        n_bad++;
        $display("FAIL bubble cyc%0d iv=%b want %b", i, issue_valid, (i % 2 == 0));
      end
      if (i == 29) begin
        n_cmp++;
        if (retired !== 4'd15) begin
          n_bad++;
          $display("FAIL retired_15 got %h want f", retired);
        end
      end
    end
    issue_ready = 1'b0;
    n_cmp++;
    if ({retired, busy} !== {4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL retired_wrap ret=%h busy=%b want 0 0", retired, busy);
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_illegal();
    test_reset_mid();
    test_clamp();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Upstream neighbour of the 16-bit ALU.
- Accepts a byte-wide instruction stream over a valid/ready handshake and assembles the opcode plus optional 16-bit little-endian immediate.
- Presents one-hot ALU strobes and a 16-bit rhs operand to the ALU/accumulator stage, held until that stage acknowledges.
- Flags illegal opcodes and counts retired instructions.

Parameters:
- CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  instruction stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted on a rising edge when in_valid&in_ready
- issue_valid  out  1  strobes and rhs valid toward ALU stage
- issue_ready  in  1  ALU stage consumes issue this cycle
- inst_add, inst_sub, inst_test, inst_and, inst_or, inst_xor, inst_not, inst_shl, inst_shr  out  1 each  one-hot ALU strobes, nonzero only while issue_valid
- rhs  out  16  ALU right-hand operand
- illegal  out  1  one-cycle pulse: illegal opcode consumed
- retired  out  CNT_W  count of completed issue handshakes
- busy  out  1  state != OPCODE

Behaviour:
- Clock and reset: one clock (clk); reset rst_n asynchronous, active-low.
- Reset values: state=OPCODE; in_ready=1; issue_valid=0; all strobes=0; rhs=0; illegal=0; retired=0; busy=0.
- Reset asserted mid-instruction discards partial opcode/immediate and any pending issue; no strobe is emitted.
- Opcode byte layout: [7:4] op, [3] long, [2:0] simm.
- op encoding: 0 add, 1 sub, 2 test, 3 and, 4 or, 5 xor, 6 not, 7 shl, 8 shr, 9–15 illegal.
- States: OPCODE, IMM_LO, IMM_HI, ISSUE.
- in_ready=1 in OPCODE/IMM_LO/IMM_HI; 0 in ISSUE.
- OPCODE, accepted byte:
  - op illegal: illegal=1 next cycle only; stay OPCODE; long/simm ignored.
  - op test or not (no operand): rhs<=0; go ISSUE.
  - long=0: rhs<=zero-extended simm; go ISSUE.
  - long=1: go IMM_LO.
- IMM_LO, accepted byte: rhs[7:0]<=byte; go IMM_HI.
- IMM_HI, accepted byte: rhs[15:8]<=byte; go ISSUE.
- Without in_valid, each state holds indefinitely; no timeout.
- ISSUE: issue_valid=1 and exactly one strobe=1 (registered, from latched op). rhs stable.
- ISSUE handshake: when issue_ready=1 on a rising edge, retired<=retired+1 (wraps), strobes and issue_valid clear, state=OPCODE.
- issue_ready while not in ISSUE is ignored.
- Latency: opcode byte accepted at edge N gives issue_valid high in cycle N+1 (short form) or after the high byte's edge (long form). Next opcode is accepted no earlier than the cycle after the issue handshake (one bubble).
- issue_valid must not drop, and strobes/rhs must not change, until the handshake completes.
- illegal and issue_valid are never high in the same cycle.

Optional Feature:
- Macro: ALU_ISSUE_SHAMT_CLAMP_EN.
- Defined: for shl/shr, a latched rhs value >16 is presented as 16. This keeps the downstream carry bit index in range. Other ops are unaffected.
- Undefined: rhs is presented exactly as assembled for every op.

Test Plan:
- Short-form: reset; send 0x05 (add, simm=5) -> issue_valid high the next cycle, inst_add=1, rhs=0x0005. Hold issue_ready=0 for 3 cycles -> outputs stable, in_ready=0. Raise issue_ready -> retired=1, state OPCODE.
- Long-form: send 0x18, 0x34, 0x12 (sub, long) -> IMM_LO then IMM_HI, then inst_sub=1, rhs=0x1234. Insert in_valid=0 gaps between bytes -> same result.
- Illegal: send 0x9F -> illegal pulses exactly one cycle; no strobe; in_ready stays 1. Following 0x60 -> inst_not=1, rhs=0.
- Reset mid-instruction: send 0x78, 0xFF then pull rst_n low asynchronously -> all outputs at reset values immediately. After release, 0x31 -> inst_and, rhs=1.
- Shift clamp: send 0x88, 0x20, 0x00 (shr, rhs 32) -> rhs=16 with ALU_ISSUE_SHAMT_CLAMP_EN defined, rhs=32 without.
- Counter wrap: CNT_W=4; 16 back-to-back issues with issue_ready tied high -> retired returns to 0. Check 1 bubble between issues.
